rvc_asap_mem_loader: RTL

- Front-door program loader for the rvc_asap core; the write-side counterpart of the core's instruction fetch path.
- Receives a framed byte stream (valid/ready) and writes it into the unified byte memory (IMem/DMem address space) while holding the core in reset.
- Releases the core once the image is loaded, then re-asserts core reset when the fetched instruction is EBREAK.
- Sits between a host/UART byte source and the memory write port; replaces the bench's backdoor force as the normal load path.

---
 rtl/rvc_asap_pkg.sv | 22 ++
 rtl/rvc_asap_hdr_assembler.sv | 29 ++
 rtl/rvc_asap_mem_loader.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/rvc_asap_pkg.sv
// Shared constants and types for the rvc_asap core and its front-door program loader.
package rvc_asap_pkg;

    localparam logic [31:0] I_MEM_MSB = 32'h0000_7FFF;
    localparam logic [31:0] D_MEM_MSB = 32'h0000_FFFF;

    // Instruction and data memories share one byte space ending at D_MEM_MSB.
    localparam logic [32:0] MEM_BYTES = {1'b0, D_MEM_MSB} + 33'd1;

    localparam logic [31:0] EBREAK_INST = 32'h0010_0073;

    typedef enum logic [2:0] {
        HDR_ADDR = 3'd0,
        HDR_LEN  = 3'd1,
        PAYLOAD  = 3'd2,
        DRAIN    = 3'd3,
        RUN      = 3'd4,
        HALTED   = 3'd5,
        ERROR    = 3'd6
    } loader_state_t;

endpackage

// File: rtl/rvc_asap_hdr_assembler.sv
// Assembles a 32-bit little-endian header field from four accepted bytes.
// Word is combinational and holds the complete field in the cycle Done pulses.
module rvc_asap_hdr_assembler (
    input  logic        Clock,
    input  logic        Rst,
    input  logic        En,
    input  logic [7:0]  Data,
    output logic [31:0] Word,
    output logic        Done
);

    logic [1:0]  idx;
    logic [23:0] shreg;

    // Bytes enter at the top and move down, so byte 0 ends up in bits [7:0].
    assign Word = {Data, shreg};
    assign Done = En && (idx == 2'd3);

    always_ff @(posedge Clock) begin
        if (Rst) begin
            idx   <= 2'd0;
            shreg <= 24'd0;
        end else if (En) begin
            idx   <= idx + 2'd1;
            shreg <= {Data, shreg[23:8]};
        end
    end

endmodule

// File: rtl/rvc_asap_mem_loader.sv
// Front-door program loader: writes a framed byte image into the unified memory
// while holding the core in reset, runs the core, and halts it on EBREAK.
module rvc_asap_mem_loader #(
    parameter logic [32:0] MEM_BYTES = rvc_asap_pkg::MEM_BYTES,
    parameter int          CNT_W     = 32
) (
    input  logic                         Clock,
    input  logic                         Rst,
    input  logic                         InValid,
    input  logic [7:0]                   InData,
    output logic                         InReady,
    output logic                         MemWrEn,
    output logic [31:0]                  MemWrAddr,
    output logic [7:0]                   MemWrData,
    input  logic [31:0]                  Instruction,
    output logic                         CoreRst,
    output logic                         Halted,
    output logic                         LoadErr,
    output logic [CNT_W-1:0]             RunCycles,
    output rvc_asap_pkg::loader_state_t  DbgState
);

    import rvc_asap_pkg::*;

    // Handshake: a byte moves only on a cycle where InValid && InReady are both
    // high; InReady depends on state alone, never on InValid.
    loader_state_t state;
    logic          accept;
    logic          addr_en;
    logic          len_en;
    logic          addr_done;
    logic          len_done;
    logic [31:0]   addr_word;
    logic [31:0]   len_word;
    logic [31:0]   wr_ptr;
    logic [31:0]   remain;
    logic [32:0]   end_addr;
    logic          range_bad;

    assign accept  = InValid && InReady;
    // A byte accepted while HALTED is byte 0 of the next StartAddr.
    assign addr_en = accept && ((state == HDR_ADDR) || (state == HALTED));
    assign len_en  = accept && (state == HDR_LEN);

    rvc_asap_hdr_assembler u_addr_asm (
        .Clock (Clock),
        .Rst   (Rst),
        .En    (addr_en),
        .Data  (InData),
        .Word  (addr_word),
        .Done  (addr_done)
    );

    rvc_asap_hdr_assembler u_len_asm (
        .Clock (Clock),
        .Rst   (Rst),
        .En    (len_en),
        .Data  (InData),
        .Word  (len_word),
        .Done  (len_done)
    );

    // 33-bit sum so an image can never wrap past the top of the address space.
    assign end_addr  = {1'b0, wr_ptr} + {1'b0, len_word};
    assign range_bad = end_addr > MEM_BYTES;

    always_comb begin
        InReady = 1'b0;
        CoreRst = 1'b1;
        Halted  = 1'b0;
        LoadErr = 1'b0;
        case (state)
            HDR_ADDR, HDR_LEN, PAYLOAD: InReady = 1'b1;
            RUN:                        CoreRst = 1'b0;
            HALTED: begin
                InReady = 1'b1;
                Halted  = 1'b1;
            end
            ERROR:                      LoadErr = 1'b1;
            default:                    InReady = 1'b0;
        endcase
    end

    assign DbgState = state;

    always_ff @(posedge Clock) begin
        if (Rst) begin
            state     <= HDR_ADDR;
            wr_ptr    <= 32'd0;
            remain    <= 32'd0;
            MemWrEn   <= 1'b0;
            MemWrAddr <= 32'd0;
            MemWrData <= 8'd0;
            RunCycles <= '0;
        end else begin
            MemWrEn <= 1'b0;
            // The start address is parked in the write pointer until the
            // length arrives and the range check has used it.
            if (addr_done) begin
                wr_ptr <= addr_word;
            end
            case (state)
                HDR_ADDR: begin
                    if (addr_done) state <= HDR_LEN;
                end
                HDR_LEN: begin
                    if (len_done) begin
                        if (range_bad) begin
                            state <= ERROR;
                        end else if (len_word == 32'd0) begin
                            state <= DRAIN;
                        end else begin
                            state  <= PAYLOAD;
                            remain <= len_word;
                        end
                    end
                end
                PAYLOAD: begin
                    if (accept) begin
                        MemWrEn   <= 1'b1;
                        MemWrAddr <= wr_ptr;
                        MemWrData <= InData;
                        wr_ptr    <= wr_ptr + 32'd1;
                        remain    <= remain - 32'd1;
                        if (remain == 32'd1) state <= DRAIN;
                    end
                end
                DRAIN: state <= RUN;
                RUN: begin
                    if (RunCycles != {CNT_W{1'b1}}) begin
                        RunCycles <= RunCycles + CNT_W'(1);
                    end
                    if (Instruction == EBREAK_INST) state <= HALTED;
                end
                HALTED: begin
                    if (accept) begin
                        RunCycles <= '0;
                        state     <= HDR_ADDR;
                    end
                end
                ERROR:   state <= ERROR;
                default: state <= ERROR;
            endcase
        end
    end

endmodule
